// File: rtl/n64_vdemux_gen_pkg.sv
// Shared constants and helpers for the N64 video demux: sync nibble bit
// positions, colour slice placement and LSB reduction.
package n64a_params;

  localparam int VSYNC = 3;
  localparam int CLAMP = 2;
  localparam int HSYNC = 1;
  localparam int CSYNC = 0;

  // ch1 sits directly below the sync nibble, chNUM_CH at the LSBs
  function automatic int ch_off(input int k, input int num_ch, input int color_w);
    return (num_ch - k) * color_w;
  endfunction

  function automatic logic [31:0] lsb_reduce(input logic [31:0] d, input int r, input int w);
    if (r >= w) return '0;
    return d & ~((32'd1 << r) - 32'd1);
  endfunction

endpackage

// File: rtl/n64_vdemux_gen.sv
// N64 digital video demux: sync nibble + NUM_CH colour words per nDSYNC group.
// Optional deblur gating is compiled in with N64_VDEMUX_DEBLUR_EN.
module n64_vdemux_gen
  import n64a_params::*;
#(
  parameter int COLOR_W  = 7,
  parameter int NUM_CH   = 3,
  parameter int SY_PHASE = 2,
  localparam int VDATA_W = 4 + NUM_CH * COLOR_W,
  localparam int CNT_W   = $clog2(NUM_CH + 3),
  localparam int RED_W   = $clog2(COLOR_W)
) (
  input  logic               nCLK,
  input  logic               nRST,
  input  logic               nDSYNC,
  input  logic [COLOR_W-1:0] D_i,
  input  logic               ndo_deblur_i,
  input  logic               nblank_rgb_i,
  input  logic [RED_W-1:0]   reduce_i,
  output logic [VDATA_W-1:0] vdata_r_0_o,
  output logic [VDATA_W-1:0] vdata_r_1_o,
  output logic               vdata_valid_o,
  output logic               phase_err_o
);

  localparam int SY_LSB = VDATA_W - 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_CH + 2);
  localparam logic [CNT_W-1:0] CNT_SY   = CNT_W'(SY_PHASE);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RED_W-1:0]   reduce_q, reduce_d;
  logic [VDATA_W-1:0] r0_q, r0_d, r1_q, r1_d;
  logic               valid_q, valid_d, err_q, err_d;
  logic               deblur;
  logic [3:0]         sync_in;
  logic [31:0]        col_full;
  logic               unused_col;

`ifdef N64_VDEMUX_DEBLUR_EN
  assign deblur = ~ndo_deblur_i;
`else
  logic unused_dbl;
  assign deblur     = 1'b0;
  assign unused_dbl = ndo_deblur_i;
`endif

  assign sync_in    = {D_i[VSYNC], D_i[CLAMP], D_i[HSYNC], D_i[CSYNC]};
  assign col_full   = lsb_reduce(32'(D_i), int'(reduce_q), COLOR_W);
  assign unused_col = ^col_full[31:COLOR_W];

  always_comb begin
    cnt_d    = cnt_q;
    reduce_d = reduce_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (!nDSYNC) begin
      cnt_d = CNT_ONE;
      r0_d[SY_LSB +: 4] = sync_in;
      // reduction only changes on the nVSYNC falling nibble, i.e. per frame
      if (r0_q[VDATA_W-1] && !D_i[VSYNC]) reduce_d = reduce_i;
      if (cnt_q >= CNT_OVR) begin
        valid_d = 1'b1;
        if (!deblur) r1_d = r0_q;
        else if (nblank_rgb_i) r1_d[SY_LSB-1:0] = r0_q[SY_LSB-1:0];
      end else if (cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else if (cnt_q != '0 && cnt_q <= CNT_LAST) begin
      r0_d[ch_off(int'(cnt_q), NUM_CH, COLOR_W) +: COLOR_W] = col_full[COLOR_W-1:0];
      cnt_d = cnt_q + CNT_ONE;
      // deblur moves the sync slice mid-group so it stays in step with the pixel
      if (deblur && cnt_q == CNT_SY) r1_d[SY_LSB +: 4] = r0_q[SY_LSB +: 4];
    end else if (cnt_q == CNT_OVR) begin
      cnt_d = CNT_SAT;
      err_d = 1'b1;
    end
  end

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      cnt_q    <= '0;
      reduce_q <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reduce_q <= reduce_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign vdata_r_0_o   = r0_q;
  assign vdata_r_1_o   = r1_q;
  assign vdata_valid_o = valid_q;
  assign phase_err_o   = err_q;

endmodule

// File: tb/tb_n64_vdemux_gen.sv
// Bench for n64_vdemux_gen: directed group scenarios with literal results,
// then random streams compared each edge against a group-level model.
module tb_n64_vdemux_gen;

  localparam int COLOR_W  = 7;
  localparam int NUM_CH   = 3;
  localparam int SY_PHASE = 2;
  localparam int VDATA_W  = 4 + NUM_CH * COLOR_W;
  localparam int RED_W    = $clog2(COLOR_W);

  logic               nCLK = 1'b1;
  logic               nRST, nDSYNC, ndo, nblank;
  logic [COLOR_W-1:0] D;
  logic [RED_W-1:0]   red_i;
  logic [VDATA_W-1:0] r0_o, r1_o;
  logic               valid_o, err_o;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // model: group-level view (sync nibble + captured colours + colours seen)
  bit  m_locked;
  int  m_ncol, m_sync, m_osync, m_red;
  int  m_ch[NUM_CH+1], m_och[NUM_CH+1];
  logic [VDATA_W-1:0] e_r0, e_r1;
  logic e_valid, e_err;

  n64_vdemux_gen #(.COLOR_W(COLOR_W), .NUM_CH(NUM_CH), .SY_PHASE(SY_PHASE)) dut (
    .nCLK(nCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D),
    .ndo_deblur_i(ndo), .nblank_rgb_i(nblank), .reduce_i(red_i),
    .vdata_r_0_o(r0_o), .vdata_r_1_o(r1_o),
    .vdata_valid_o(valid_o), .phase_err_o(err_o)
  );

  always #5 nCLK = ~nCLK;

  task automatic chkv(input string nm, input logic [VDATA_W-1:0] act, input logic [VDATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [VDATA_W-1:0] pack(input int s, input int ch[NUM_CH+1]);
    logic [VDATA_W-1:0] v;
    v = VDATA_W'(s & 15);
    for (int k = 1; k <= NUM_CH; k++) v = (v << COLOR_W) | VDATA_W'(ch[k]);
    return v;
  endfunction

  task automatic model_step();
    bit dbl;
`ifdef N64_VDEMUX_DEBLUR_EN
    dbl = !ndo;
`else
    dbl = 1'b0;
`endif
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!nRST) begin
      m_locked = 0; m_ncol = 0; m_sync = 0; m_osync = 0; m_red = 0;
      for (int k = 0; k <= NUM_CH; k++) begin m_ch[k] = 0; m_och[k] = 0; end
    end else if (!nDSYNC) begin
      if (m_locked && m_ncol >= NUM_CH) begin
        e_valid = 1'b1;
        if (!dbl || nblank) for (int k = 1; k <= NUM_CH; k++) m_och[k] = m_ch[k];
        if (!dbl) m_osync = m_sync;
      end else if (m_locked) begin
        e_err = 1'b1;
      end
      if ((m_sync & 8) != 0 && !D[3]) m_red = int'(red_i);
      m_sync = int'(D) & 15;
      m_locked = 1;
      m_ncol = 0;
    end else if (m_locked) begin
      m_ncol++;
      if (m_ncol <= NUM_CH) begin
        m_ch[m_ncol] = (m_red >= COLOR_W) ? 0 : ((int'(D) >> m_red) << m_red);
        if (dbl && m_ncol == SY_PHASE) m_osync = m_sync;
      end else if (m_ncol == NUM_CH + 1) begin
        e_err = 1'b1;
      end else begin
        m_ncol = NUM_CH + 2;
      end
    end
    e_r0 = pack(m_sync, m_ch);
    e_r1 = pack(m_osync, m_och);
  endtask

  // drive one nCLK cycle; returns at the rising edge after the sampling edge
  task automatic cyc(input logic nds, input int d);
    nDSYNC = nds;
    D = COLOR_W'(d);
    model_step();
    @(posedge nCLK);
  endtask

  always @(negedge nCLK) begin
    #1;
    if (chk_en) begin
      chkv("cmp_r0", r0_o, e_r0);
      chkv("cmp_r1", r1_o, e_r1);
      chkb("cmp_valid", valid_o, e_valid);
      chkb("cmp_err", err_o, e_err);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; nDSYNC = 1'b1; D = '0; ndo = 1'b1; nblank = 1'b1; red_i = '0;
    cyc(1, 0);
    cyc(1, 0);
    chk_en = 1'b1;
    chkv("rst_r0", r0_o, '0);
    chkv("rst_r1", r1_o, '0);
    chkb("rst_valid", valid_o, 1'b0);
    chkb("rst_err", err_o, 1'b0);
    nRST = 1'b1;

    // first group after reset is not output
    cyc(0, 'h0F); chkb("first_valid", valid_o, 1'b0);
    cyc(1, 'h55); cyc(1, 'h2A); cyc(1, 'h7F);
    cyc(0, 'h0F);
    chkb("grp_valid", valid_o, 1'b1);
    chkv("grp_r1", r1_o, {4'hF, 7'h55, 7'h2A, 7'h7F});

    // mid-frame reduce change has no effect
    red_i = 2;
    cyc(1, 'h55); cyc(1, 'h2A); cyc(1, 'h7F);
    chkv("midframe_r0", r0_o, {4'hF, 7'h55, 7'h2A, 7'h7F});
    cyc(0, 'h07);
    chkv("midframe_r1", r1_o, {4'hF, 7'h55, 7'h2A, 7'h7F});
    cyc(1, 'h55); cyc(1, 'h2A); cyc(1, 'h7F);
    chkv("reduced_r0", VDATA_W'(r0_o[20:0]), VDATA_W'({7'h54, 7'h28, 7'h7C}));
    cyc(0, 'h07);
    chkv("reduced_r1", r1_o, {4'h7, 7'h54, 7'h28, 7'h7C});

    // short group
    cyc(1, 'h01); cyc(1, 'h02);
    cyc(0, 'h07);
    chkb("short_err", err_o, 1'b1);
    chkb("short_valid", valid_o, 1'b0);
    chkv("short_r1", r1_o, {4'h7, 7'h54, 7'h28, 7'h7C});
    cyc(1, 'h11); cyc(1, 'h22); cyc(1, 'h33);
    cyc(0, 'h07);
    chkb("recover_valid", valid_o, 1'b1);
    chkv("recover_r1", r1_o, {4'h7, 7'h10, 7'h20, 7'h30});

    // overrun group
    cyc(1, 'h11); cyc(1, 'h22); cyc(1, 'h33);
    cyc(1, 'h44); chkb("ovr_err", err_o, 1'b1);
    cyc(1, 'h55); chkb("ovr_err_once", err_o, 1'b0);
    chkv("ovr_ch3", VDATA_W'(r0_o[6:0]), VDATA_W'(7'h30));
    cyc(0, 'h07);
    chkb("ovr_valid", valid_o, 1'b1);
    chkv("ovr_r1", r1_o, {4'h7, 7'h10, 7'h20, 7'h30});

    // reset mid-group
    cyc(1, 'h11);
    nRST = 1'b0;
    cyc(1, 'h22);
    chkv("mrst_r0", r0_o, '0);
    chkv("mrst_r1", r1_o, '0);
    chkb("mrst_valid", valid_o, 1'b0);
    nRST = 1'b1;
    cyc(0, 'h0F); chkb("mrst_first_valid", valid_o, 1'b0);
    cyc(1, 1); cyc(1, 2); cyc(1, 3);
    cyc(0, 'h0E);
    chkv("mrst_r1_grp", r1_o, {4'hF, 7'h01, 7'h02, 7'h03});

`ifdef N64_VDEMUX_DEBLUR_EN
    ndo = 1'b0; nblank = 1'b0;
    cyc(1, 4); cyc(1, 5);
    chkv("dbl_sync_move", r1_o, {4'hE, 7'h01, 7'h02, 7'h03});
    cyc(1, 6);
    cyc(0, 'h0D);
    chkb("dbl_valid", valid_o, 1'b1);
    chkv("dbl_hold", r1_o, {4'hE, 7'h01, 7'h02, 7'h03});
    ndo = 1'b1; nblank = 1'b1;
`endif

    for (int i = 0; i < 4000; i++) begin
      nRST   = ($urandom_range(0, 299) != 0);
      red_i  = RED_W'($urandom_range(0, 7));
      ndo    = 1'($urandom_range(0, 1));
      nblank = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1, int'($urandom_range(0, 127)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
